// File: rtl/video_timing_pkg.sv
// Shared definitions for the video FIFO reader: FSM states, default 720p
// timing and helpers that derive line/frame totals and counter widths.
package video_timing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width; never below one bit so degenerate timings still elaborate.
    function automatic int timing_width(input int active, input int fp,
                                        input int sync, input int bp);
        int total;
        total = timing_total(active, fp, sync, bp);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/video_fifo_reader_if.sv
// Bus bundle between the video FIFO reader and its environment: FIFO read
// port, frame request, video pins and underflow status/control.
interface video_fifo_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  enable;
    logic                  fifo_rd_en;
    logic                  fifo_rd_vld;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  frame_req;
    logic                  vid_hs;
    logic                  vid_vs;
    logic                  vid_de;
    logic [DATA_WIDTH-1:0] vid_data;
    logic                  underflow;
    logic [15:0]           underflow_cnt;
    logic                  underflow_clr;

    // Reader side
    modport master (
        input  enable, fifo_rd_vld, fifo_rd_data, underflow_clr,
        output fifo_rd_en, frame_req, vid_hs, vid_vs, vid_de, vid_data,
               underflow, underflow_cnt
    );

    // FIFO / system side
    modport slave (
        output enable, fifo_rd_vld, fifo_rd_data, underflow_clr,
        input  fifo_rd_en, frame_req, vid_hs, vid_vs, vid_de, vid_data,
               underflow, underflow_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with region decode. The counters can
// be held, loaded to the start of vertical blanking, or cleared to zero.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_run_i,
    input  logic load_start_i,
    input  logic load_zero_i,
    output logic de_o,
    output logic hs_o,
    output logic vs_o,
    output logic pre_vblank_o,
    output logic frame_end_o
);
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = timing_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VW      = timing_width(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_START = VW'(V_ACTIVE);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    int            h_pos, v_pos;

    // Next counter position: explicit loads win over free-running.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (load_start_i) begin
            h_cnt_d = '0;
            v_cnt_d = V_START;
        end else if (load_zero_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (cnt_run_i) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region decode on the current position, compared in int so the
    // sync end bounds may equal the total without overflowing the counter width.
    always_comb begin
        h_pos        = int'(h_cnt_q);
        v_pos        = int'(v_cnt_q);
        de_o         = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
        hs_o         = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
        vs_o         = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
        pre_vblank_o = (h_cnt_q == H_LAST) && (v_pos == V_ACTIVE - 1);
        frame_end_o  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    end

endmodule

// File: rtl/video_fifo_reader.sv
// Pixel-clock consumer of the prefetch read FIFO: runs the video raster,
// pops one word per active pixel, requests frames at vblank start and
// substitutes black (counting the event) when the FIFO runs dry.
module video_fifo_reader
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int HS_POL     = 1,
    parameter int VS_POL     = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    video_fifo_reader_if.master bus
);
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    state_t                state_q, state_d;
    logic                  de_int, hs_int, vs_int, pre_vblank, frame_end;
    logic                  cnt_run, load_start, load_zero, fr_set;
    logic                  active, pop, starve;
    logic                  frame_req_q, vid_hs_q, vid_vs_q, vid_de_q;
    logic [DATA_WIDTH-1:0] vid_data_q;
    logic                  underflow_q;
    logic [15:0]           underflow_cnt_q;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (rd_clk),
        .rst_n        (rd_rst_n),
        .cnt_run_i    (cnt_run),
        .load_start_i (load_start),
        .load_zero_i  (load_zero),
        .de_o         (de_int),
        .hs_o         (hs_int),
        .vs_o         (vs_int),
        .pre_vblank_o (pre_vblank),
        .frame_end_o  (frame_end)
    );

    // State register.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state and counter controls. Starting enters at vblank so the
    // upstream reader gets a whole blanking interval to prefetch; fr_set is
    // raised the cycle before the counters reach the vblank start position.
    always_comb begin
        state_d    = state_q;
        cnt_run    = 1'b0;
        load_start = 1'b0;
        load_zero  = 1'b0;
        fr_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d    = RUN;
                    load_start = 1'b1;
                    fr_set     = 1'b1;
                end
            end
            RUN: begin
                cnt_run = 1'b1;
                if (!bus.enable) state_d = STOP;
                else if (pre_vblank) fr_set = 1'b1;
            end
            STOP: begin
                cnt_run = 1'b1;
                if (bus.enable) begin
                    state_d = RUN;
                    fr_set  = pre_vblank;
                end else if (frame_end) begin
                    state_d   = IDLE;
                    load_zero = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The counters sit at (0,0) in IDLE, which decodes as active, so every
    // FIFO and pin effect is qualified by a non-idle state.
    assign active = (state_q != IDLE);
    assign pop    = active && de_int && bus.fifo_rd_vld;
    assign starve = active && de_int && !bus.fifo_rd_vld;

    // Single output pipeline stage; blanking and starved pixels drive black.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            frame_req_q <= 1'b0;
            vid_hs_q    <= ~HS_ACT;
            vid_vs_q    <= ~VS_ACT;
            vid_de_q    <= 1'b0;
            vid_data_q  <= '0;
        end else begin
            frame_req_q <= fr_set;
            vid_hs_q    <= (active && hs_int) ? HS_ACT : ~HS_ACT;
            vid_vs_q    <= (active && vs_int) ? VS_ACT : ~VS_ACT;
            vid_de_q    <= active && de_int;
            vid_data_q  <= pop ? bus.fifo_rd_data : '0;
        end
    end

    // Sticky underflow flag and saturating count; clear beats a new event.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n || bus.underflow_clr) begin
            underflow_q     <= 1'b0;
            underflow_cnt_q <= '0;
        end else if (starve) begin
            underflow_q <= 1'b1;
            if (underflow_cnt_q != 16'hFFFF) underflow_cnt_q <= underflow_cnt_q + 16'd1;
        end
    end

    assign bus.fifo_rd_en    = pop;
    assign bus.frame_req     = frame_req_q;
    assign bus.vid_hs        = vid_hs_q;
    assign bus.vid_vs        = vid_vs_q;
    assign bus.vid_de        = vid_de_q;
    assign bus.vid_data      = vid_data_q;
    assign bus.underflow     = underflow_q;
    assign bus.underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_video_fifo_reader.sv
// Self-checking bench for video_fifo_reader on a tiny 14x7 raster, compared
// cycle by cycle against a frame-position reference model.
module tb_video_fifo_reader;
    localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;   // 14
    localparam int VT = VA + VFP + VSW + VBP;   // 7
    localparam int FRAME = HT * VT;             // 98

    logic rd_clk = 1'b0;
    logic rd_rst_n;
    always #5 rd_clk = ~rd_clk;

    video_fifo_reader_if #(.DATA_WIDTH(16)) bus ();

    video_fifo_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1), .VS_POL(1), .DATA_WIDTH(16)
    ) dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle_no = 0;

    // Reference model: running flag, stopping flag and linear position in frame.
    bit          m_active, m_stop;
    int          m_pos;
    logic [15:0] m_head;
    logic        m_fr, m_hs, m_vs, m_de, m_uf, exp_rd_en, obs_rd_en;
    logic [15:0] m_data, m_cnt;
    logic [37:0] obs_vec, exp_vec;

    function automatic void model_reset();
        m_active = 0; m_stop = 0; m_pos = 0;
        m_fr = 0; m_hs = 0; m_vs = 0; m_de = 0; m_data = '0; m_uf = 0; m_cnt = '0;
    endfunction

    // One pixel clock: drive inputs, sample fifo_rd_en before the edge,
    // advance the model, sample registered pins 1 ns after the edge.
    task automatic step(input bit rst_n, input bit en, input bit vld, input bit clr);
        int h, v;
        bit de_int, old_active;
        int old_pos;
        rd_rst_n          = rst_n;
        bus.enable        = en;
        bus.fifo_rd_vld   = vld;
        bus.underflow_clr = clr;
        bus.fifo_rd_data  = vld ? m_head : 16'($urandom);
        #3;
        h = m_pos % HT;
        v = m_pos / HT;
        de_int    = m_active && (h < HA) && (v < VA);
        exp_rd_en = de_int && vld;
        obs_rd_en = bus.fifo_rd_en;
        @(posedge rd_clk);
        #1;
        cycle_no++;
        old_active = m_active;
        old_pos    = m_pos;
        if (exp_rd_en) m_head = m_head + 16'd1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_de   = de_int;
            m_hs   = m_active && (h >= HA + HFP) && (h < HA + HFP + HSW);
            m_vs   = m_active && (v >= VA + VFP) && (v < VA + VFP + VSW);
            m_data = exp_rd_en ? bus.fifo_rd_data : 16'h0000;
            m_fr   = en && (!old_active || old_pos == VA * HT - 1);
            if (clr) begin
                m_uf = 0; m_cnt = '0;
            end else if (de_int && !vld) begin
                m_uf = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (!old_active) begin
                if (en) begin m_active = 1; m_stop = 0; m_pos = VA * HT; end
            end else begin
                if (en) m_stop = 0;
                else if (m_stop && old_pos == FRAME - 1) m_active = 0;
                else m_stop = 1;
                m_pos = m_active ? (old_pos + 1) % FRAME : 0;
            end
        end
        obs_vec = {obs_rd_en, bus.frame_req, bus.vid_hs, bus.vid_vs, bus.vid_de,
                   bus.vid_data, bus.underflow, bus.underflow_cnt};
        exp_vec = {exp_rd_en, m_fr, m_hs, m_vs, m_de, m_data, m_uf, m_cnt};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 0, ($urandom_range(0, 1) == 1), 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        $display("test_reset done at cycle %0d", cycle_no);
    endtask

    task automatic test_stream();
        int fr1 = -1, fr2 = -1, de_rise = -1, pops = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1, 1, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL stream cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
            if (fr1 >= 0 && fr2 < 0 && obs_rd_en === 1'b1) pops++;
            if (bus.frame_req === 1'b1) begin
                if (fr1 < 0) fr1 = cycle_no;
                else if (fr2 < 0) fr2 = cycle_no;
            end
            if (fr1 >= 0 && de_rise < 0 && bus.vid_de === 1'b1) de_rise = cycle_no;
        end
        vectors++;
        if (fr2 - fr1 !== FRAME || fr1 < 0) begin
            miscompares++;
            $display("FAIL frame_period: got %0d want %0d", fr2 - fr1, FRAME);
        end
        vectors++;
        if (de_rise - fr1 !== 3 * HT + 1) begin
            miscompares++;
            $display("FAIL de_latency: got %0d want %0d", de_rise - fr1, 3 * HT + 1);
        end
        vectors++;
        if (pops !== HA * VA) begin
            miscompares++;
            $display("FAIL pops_per_frame: got %0d want %0d", pops, HA * VA);
        end
        $display("test_stream done at cycle %0d", cycle_no);
    endtask

    task automatic test_underflow();
        bit found = 0;
        step(1, 1, 1, 1);
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL uf_clr0 cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
        end
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step(1, 1, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL uf_seek cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
            found = m_active && (m_pos % HT == 2) && (m_pos / HT < VA);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL uf_seek_timeout: got no mid-line pixel want one");
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL uf_drop cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        vectors++;
        if ({bus.underflow, bus.underflow_cnt} !== {1'b1, 16'd3}) begin
            miscompares++;
            $display("FAIL uf_count: got %b/%0d want 1/3", bus.underflow, bus.underflow_cnt);
        end
        step(1, 1, 1, 1);
        vectors++;
        if ({bus.underflow, bus.underflow_cnt} !== 17'd0) begin
            miscompares++;
            $display("FAIL uf_clear: got %b/%0d want 0/0", bus.underflow, bus.underflow_cnt);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1, 1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL uf_random cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        $display("test_underflow done at cycle %0d", cycle_no);
    endtask

    task automatic test_stop();
        int stray_fr = 0;
        for (int i = 0; i < 2 * FRAME && !(m_active && m_pos / HT == 1); i++) begin
            step(1, 1, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL stop_seek cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 2 * FRAME && m_active; i++) begin
            step(1, 0, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL stop_drain cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
            if (bus.frame_req === 1'b1) stray_fr++;
        end
        vectors++;
        if (stray_fr !== 0 || m_active) begin
            miscompares++;
            $display("FAIL stop_frame_req: got %0d pulses want 0", stray_fr);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL stop_idle cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        $display("test_stop done at cycle %0d", cycle_no);
    endtask

    task automatic test_reenable();
        int gap = $urandom_range(5, 30);
        for (int i = 0; i < 60 + gap + 150; i++) begin
            step(1, (i < 60 || i >= 60 + gap), ($urandom_range(0, 7) != 0), 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reenable cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        $display("test_reenable done at cycle %0d (gap %0d)", cycle_no, gap);
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 2 * FRAME && !(m_de && m_pos % HT == 4); i++) begin
            step(1, 1, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rst_seek cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        step(0, 1, 1, 0);
        vectors++;
        if ({bus.vid_de, bus.vid_hs, bus.vid_vs, bus.frame_req, bus.vid_data,
             bus.underflow, bus.underflow_cnt} !== 37'd0) begin
            miscompares++;
            $display("FAIL rst_midline: got de%b hs%b vs%b fr%b data %h want all zero",
                     bus.vid_de, bus.vid_hs, bus.vid_vs, bus.frame_req, bus.vid_data);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rst_after cyc %0d: got %h want %h", cycle_no, obs_vec, exp_vec);
            end
        end
        $display("test_reset_midline done at cycle %0d", cycle_no);
    endtask

    initial begin
        rd_rst_n          = 1'b0;
        bus.enable        = 1'b0;
        bus.fifo_rd_vld   = 1'b0;
        bus.fifo_rd_data  = '0;
        bus.underflow_clr = 1'b0;
        m_head            = 16'($urandom);
        model_reset();
        repeat (2) @(posedge rd_clk);
        #1;
        test_reset();
        test_stream();
        test_underflow();
        test_stop();
        test_reenable();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
